// File: rtl/i2c_sched_if.sv
// -----------------------------------------------------------------------------
// i2c_sched_if
//   Bundles the request/grant handshake of the two requesters with the
//   beg/scl pair of the shared I2C master.
//
//   Signals:
//     req0, req1   request strobes from the requesters
//     gnt0, gnt1   ownership levels back to the requesters
//     done0, done1 one-cycle end-of-transaction pulses
//     err          one-cycle pulse alongside doneX when the watchdog expired
//     m_beg        level to the master's beg input
//     m_scl        master's scl, observed for end-of-transaction detection
//
//   Modports:
//     slave   the scheduler (i2c_sched)
//     master  the requester/master side driving it
// -----------------------------------------------------------------------------
interface i2c_sched_if;
    logic req0;
    logic req1;
    logic gnt0;
    logic gnt1;
    logic done0;
    logic done1;
    logic err;
    logic m_beg;
    logic m_scl;

    modport slave (
        input  req0, req1, m_scl,
        output gnt0, gnt1, done0, done1, err, m_beg
    );

    modport master (
        output req0, req1, m_scl,
        input  gnt0, gnt1, done0, done1, err, m_beg
    );
endinterface

// File: rtl/i2c_sched.sv
// -----------------------------------------------------------------------------
// i2c_sched
//   Transaction scheduler and round-robin arbiter for a single I2C master
//   shared by two requesters. Requests are latched into pending bits; in IDLE
//   the scheduler grants one requester and raises m_beg. The transaction is
//   considered finished once scl has been seen low and then stays high for
//   IDLE_CYC consecutive cycles. A watchdog ends ownership after TIMEOUT_CYC
//   cycles regardless. m_beg is then held low for GAP_CYC cycles so the master
//   can fall back from Wait to Default before the next grant.
//
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    i2c_sched_if.slave (req0/1, gnt0/1, done0/1, err, m_beg, m_scl)
//
//   Parameters:
//     IDLE_CYC     scl-high cycles that mark the end of a transaction
//     TIMEOUT_CYC  maximum cycles from grant to finish
//     GAP_CYC      cycles m_beg stays low between transactions (>= 2)
//     POLL_DIV     auto-poll period in cycles
//
//   Build option:
//     I2C_SCHED_AUTOPOLL_EN  when defined, a free-running counter injects a
//                            one-cycle request on requester 0 every POLL_DIV
//                            cycles. When undefined, POLL_DIV is unused.
// -----------------------------------------------------------------------------
module i2c_sched #(
    parameter int unsigned IDLE_CYC    = 1000,
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned POLL_DIV    = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    i2c_sched_if.slave bus
);

    localparam int IDLE_W = $clog2(IDLE_CYC) + 1;
    localparam int WD_W   = $clog2(TIMEOUT_CYC) + 1;
    localparam int GAP_W  = $clog2(GAP_CYC) + 1;

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYC - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
    // RELEASE lasts GAP_CYC-1 cycles; the one IDLE cycle before the next
    // grant completes the GAP_CYC-cycle low phase of m_beg.
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 2);

    if (GAP_CYC < 2) begin : g_bad_gap
        $error("i2c_sched: GAP_CYC must be at least 2");
    end
    if (POLL_DIV < 2) begin : g_bad_poll
        $error("i2c_sched: POLL_DIV must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic                pend0_q, pend1_q;
    logic                last_q;       // index of the most recent grant, i.e. the current owner in RUN
    logic                seen_low_q;   // scl has gone low at least once in this transaction
    logic [IDLE_W-1:0]   idle_cnt_q;
    logic [WD_W-1:0]     wd_cnt_q;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic                done0_q, done1_q, err_q;

    logic                start;        // IDLE -> RUN this cycle
    logic                grant_idx;
    logic                finish;       // RUN -> RELEASE this cycle
    logic                finish_err;
    logic                idle_hit;
    logic                wd_hit;
    logic                poll_stb;
    logic                req0_eff;

`ifdef I2C_SCHED_AUTOPOLL_EN
    localparam int                POLL_W    = $clog2(POLL_DIV) + 1;
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_DIV - 1);

    logic [POLL_W-1:0] poll_cnt_q;

    // Free-running from reset; it does not care whether requester 0 is
    // currently pending or granted, the pending bit absorbs duplicates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt_q <= '0;
        end else if (poll_cnt_q == POLL_LAST) begin
            poll_cnt_q <= '0;
        end else begin
            poll_cnt_q <= poll_cnt_q + 1'b1;
        end
    end

    assign poll_stb = (poll_cnt_q == POLL_LAST);
`else
    assign poll_stb = 1'b0;
`endif

    assign req0_eff = bus.req0 | poll_stb;

    // scl high only counts once the master has left its Start phase.
    assign idle_hit = bus.m_scl && seen_low_q && (idle_cnt_q == IDLE_LAST);
    assign wd_hit   = (wd_cnt_q == WD_LAST);

    // NOTE: every signal assigned in this block gets its default first, so
    // no path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        grant_idx  = last_q;
        finish     = 1'b0;
        finish_err = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pend0_q || pend1_q) begin
                    start     = 1'b1;
                    // A tie goes to whoever was not served last.
                    grant_idx = (pend0_q && pend1_q) ? ~last_q : pend1_q;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                // Idle completion wins over a simultaneous watchdog expiry.
                if (idle_hit || wd_hit) begin
                    finish     = 1'b1;
                    finish_err = !idle_hit;
                    state_d    = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend0_q    <= 1'b0;
            pend1_q    <= 1'b0;
            last_q     <= 1'b1;
            seen_low_q <= 1'b0;
            idle_cnt_q <= '0;
            wd_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // A request in the grant cycle survives the clear: set wins.
            pend0_q <= req0_eff | (pend0_q & ~(start & ~grant_idx));
            pend1_q <= bus.req1 | (pend1_q & ~(start &  grant_idx));

            if (start) begin
                last_q <= grant_idx;
            end

            done0_q <= finish & ~last_q;
            done1_q <= finish &  last_q;
            err_q   <= finish_err;

            case (state_q)
                S_IDLE: begin
                    // Holding these cleared in IDLE means RUN always starts fresh.
                    seen_low_q <= 1'b0;
                    idle_cnt_q <= '0;
                    wd_cnt_q   <= '0;
                    gap_cnt_q  <= '0;
                end
                S_RUN: begin
                    wd_cnt_q  <= wd_cnt_q + 1'b1;
                    gap_cnt_q <= '0;
                    if (!bus.m_scl) begin
                        seen_low_q <= 1'b1;
                        idle_cnt_q <= '0;
                    end else if (seen_low_q) begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    gap_cnt_q <= gap_cnt_q + 1'b1;
                end
                default: begin
                    gap_cnt_q <= '0;
                end
            endcase
        end
    end

    // Decoded from state so they drop the moment reset is asserted.
    assign bus.m_beg = (state_q == S_RUN);
    assign bus.gnt0  = (state_q == S_RUN) && !last_q;
    assign bus.gnt1  = (state_q == S_RUN) &&  last_q;
    assign bus.done0 = done0_q;
    assign bus.done1 = done1_q;
    assign bus.err   = err_q;

endmodule
